taxi_trip_ctrl: RTL
===================

Name: taxi_trip_ctrl

Overview:
Trip sequencer for the taxi meter. It turns the settle/pause/display buttons into trip states, generates the 0.5 s metering tick, and updates distance, fare and the accumulated total. It sits between the button inputs and the BCD/seven-segment display path, and drives the value that path shows.

Parameters:
TICK_DIV, 25000000, clk cycles per metering tick (0.5 s at 50 MHz)
BASE_FARE, 100000, fare at trip start (units of 0.0001 currency)
STEP_M, 100, metres added per running tick
START_M, 3000, lower distance bound of the mid-rate band
MID_M, 10000, upper distance bound of the mid-rate band (inclusive)
RATE_MID, 2400, fare added per tick in the mid band
RATE_HIGH, 3600, fare added per tick above MID_M
RATE_WAIT, 5000, fare added per tick while paused

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
settle_btn  in  1  level from button; rising edge starts or settles a trip
pause  in  1  level; high = waiting (meter stopped, wait rate applies)
show_total_btn  in  1  level; rising edge toggles the display source
fare  out  32  current or last trip fare
meter  out  32  current or last trip distance, metres
total  out  32  sum of settled fares
running  out  1  high in RUN or WAIT
disp_sel  out  1  0 = fare shown, 1 = total shown
disp_value  out  32  registered mux: disp_sel ? total : fare
tick  out  1  one-cycle metering strobe

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, fare=BASE_FARE, meter=0, total=0, disp_sel=0, disp_value=BASE_FARE, tick=0, divider=0, edge-detect history=0.
- Edge detect: a rising edge is a registered previous value of 0 and a current value of 1. An edge acts one cycle after the input rises.
- FSM states: IDLE, RUN, WAIT, SETTLE.
  - IDLE + settle edge: fare=BASE_FARE, meter=0. Go to RUN if pause=0, or to WAIT if pause=1.
  - RUN and WAIT follow the pause level each cycle.
  - RUN/WAIT + settle edge: go to SETTLE. A settle edge takes priority over a pause change in the same cycle.
  - SETTLE lasts exactly one cycle: total <= total + fare, saturating at 32'hFFFFFFFF. Then go to IDLE.
  - In IDLE, fare and meter hold the last trip's values.
- Divider:
  - Counts 0..TICK_DIV-1 only in RUN/WAIT; cleared in IDLE/SETTLE.
  - tick=1 for one cycle when the count equals TICK_DIV-1. The first tick therefore occurs TICK_DIV cycles after entering RUN/WAIT.
  - The count is not cleared on RUN<->WAIT transitions.
- On tick in RUN, decisions use the pre-tick meter value:
  - meter += STEP_M.
  - fare += RATE_MID if START_M <= meter <= MID_M.
  - fare += RATE_HIGH if meter > MID_M.
  - Otherwise fare is unchanged.
- On tick in WAIT: meter unchanged; fare += RATE_WAIT.
- Saturation: meter and fare saturate at 32'hFFFFFFFF and never wrap.
- A tick coinciding with a settle edge is applied first. SETTLE then adds the updated fare.
- show_total edge toggles disp_sel in any state. A show_total edge and a settle edge in the same cycle are both honoured.
- disp_value updates one cycle after fare, total or disp_sel changes.
- Reset mid-trip: everything, including total, returns to reset values at that edge.

Optional Feature:
TAXI_NIGHT_SURCHARGE_EN
- Defined:
  - Adds an input port night (1 bit).
  - night is sampled on the IDLE->RUN/WAIT transition and held for the whole trip.
  - If the sampled value is 1, the base fare and every rate become value + (value >> 2), i.e. 125000, 3000, 4500 and 6250 with the defaults.
- Undefined: no night port and no surcharge logic.

Decomposition:
- Package taxi_pkg holds:
  - the state enum (IDLE, RUN, WAIT, SETTLE);
  - the fare and distance default constants;
  - the 32-bit fare and metre types;
  - a saturating-add function.
- One sub-module, taxi_tick_div, contains the parameterised divider with a clear input and a one-cycle tick output.

Test Plan (bench TICK_DIV=4):
1. Reset -> fare=100000, meter=0, total=0, running=0, disp_value=100000, no tick for 20 cycles.
2. Settle edge, pause=0, 30 ticks -> meter=3000, fare=100000. 31st tick -> meter=3100, fare=102400.
3. Continue to meter=10100, then one more tick -> fare increases by 3600, meter=10200.
4. Mid-trip pause=1 for 4 ticks -> meter unchanged, fare +20000, running=1. pause=0 -> metering resumes.
5. Settle edge -> one SETTLE cycle, total=fare, running=0. Second trip of 30 ticks then settle -> total = first fare + 100000. show_total edge -> disp_sel=1, disp_value=total next cycle.
6. rst_n low mid-trip for one edge -> all outputs at reset values. A settle edge coinciding with a tick -> total includes that tick's increment.

Source files
------------

// File: rtl/taxi_pkg.sv
// Shared types, default constants and saturating arithmetic for the taxi meter.
package taxi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    WAIT   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  typedef logic [31:0] fare_t;
  typedef logic [31:0] metre_t;

  localparam int unsigned TICK_DIV_DEF  = 25000000;
  localparam fare_t       BASE_FARE_DEF = 32'd100000;
  localparam metre_t      STEP_M_DEF    = 32'd100;
  localparam metre_t      START_M_DEF   = 32'd3000;
  localparam metre_t      MID_M_DEF     = 32'd10000;
  localparam fare_t       RATE_MID_DEF  = 32'd2400;
  localparam fare_t       RATE_HIGH_DEF = 32'd3600;
  localparam fare_t       RATE_WAIT_DEF = 32'd5000;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/taxi_tick_div.sv
// Metering tick divider: counts while enabled, strobes tick on the last count.
module taxi_tick_div #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick = ~clr && (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/taxi_trip_ctrl.sv
// Taxi trip sequencer: button edges -> trip FSM, metering tick, fare/distance/total.
// Optional night surcharge enabled by defining TAXI_NIGHT_SURCHARGE_EN.
module taxi_trip_ctrl
  import taxi_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter fare_t       BASE_FARE = BASE_FARE_DEF,
  parameter metre_t      STEP_M    = STEP_M_DEF,
  parameter metre_t      START_M   = START_M_DEF,
  parameter metre_t      MID_M     = MID_M_DEF,
  parameter fare_t       RATE_MID  = RATE_MID_DEF,
  parameter fare_t       RATE_HIGH = RATE_HIGH_DEF,
  parameter fare_t       RATE_WAIT = RATE_WAIT_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   settle_btn,
  input  logic   pause,
  input  logic   show_total_btn,
`ifdef TAXI_NIGHT_SURCHARGE_EN
  input  logic   night,
`endif
  output fare_t  fare,
  output metre_t meter,
  output fare_t  total,
  output logic   running,
  output logic   disp_sel,
  output fare_t  disp_value,
  output logic   tick
);

  state_t state_q, state_d;
  logic   settle_q, show_q;
  logic   settle_edge, show_edge;
  logic   div_clr;
  fare_t  base_eff, mid_eff, high_eff, wait_eff, run_rate;

  assign settle_edge = settle_btn & ~settle_q;
  assign show_edge   = show_total_btn & ~show_q;
  assign running     = (state_q == RUN) || (state_q == WAIT);
  assign div_clr     = ~running;

`ifdef TAXI_NIGHT_SURCHARGE_EN
  logic night_q;

  function automatic fare_t surch(input fare_t v);
    return sat_add(v, v >> 2);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      night_q <= 1'b0;
    end else if (state_q == IDLE && settle_edge) begin
      night_q <= night;
    end
  end

  // Base fare is loaded on the same edge night is captured, so use the live input.
  assign base_eff = night   ? surch(BASE_FARE) : BASE_FARE;
  assign mid_eff  = night_q ? surch(RATE_MID)  : RATE_MID;
  assign high_eff = night_q ? surch(RATE_HIGH) : RATE_HIGH;
  assign wait_eff = night_q ? surch(RATE_WAIT) : RATE_WAIT;
`else
  assign base_eff = BASE_FARE;
  assign mid_eff  = RATE_MID;
  assign high_eff = RATE_HIGH;
  assign wait_eff = RATE_WAIT;
`endif

  taxi_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .tick  (tick)
  );

  always_comb begin
    run_rate = '0;
    if (meter > MID_M) begin
      run_rate = high_eff;
    end else if (meter >= START_M) begin
      run_rate = mid_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Settle edge wins over a same-cycle pause change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (settle_edge) state_d = pause ? WAIT : RUN;
      RUN, WAIT: state_d = settle_edge ? SETTLE : (pause ? WAIT : RUN);
      SETTLE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A tick on the settle edge updates fare first; SETTLE then sees the updated value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fare       <= BASE_FARE;
      meter      <= '0;
      total      <= '0;
      disp_sel   <= 1'b0;
      disp_value <= BASE_FARE;
      settle_q   <= 1'b0;
      show_q     <= 1'b0;
    end else begin
      settle_q   <= settle_btn;
      show_q     <= show_total_btn;
      disp_value <= disp_sel ? total : fare;
      if (show_edge) disp_sel <= ~disp_sel;
      case (state_q)
        IDLE: begin
          if (settle_edge) begin
            fare  <= base_eff;
            meter <= '0;
          end
        end
        RUN: begin
          if (tick) begin
            meter <= sat_add(meter, STEP_M);
            fare  <= sat_add(fare, run_rate);
          end
        end
        WAIT: begin
          if (tick) fare <= sat_add(fare, wait_eff);
        end
        SETTLE: total <= sat_add(total, fare);
        default: ;
      endcase
    end
  end

endmodule
